// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the four-master system bus arbiter.
// Holds the FSM state encoding, the fixed master slot numbering and a
// small one-hot helper used for grant / acknowledge vectors.
package bus_arbiter4_pkg;

  // Arbiter FSM states. Encoding is fixed so the state can be probed
  // from a debug register without a lookup table.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Master slot numbering on the 4:1 bus muxes.
  localparam logic [1:0] M_IFETCH = 2'd0;
  localparam logic [1:0] M_DATA   = 2'd1;
  localparam logic [1:0] M_VGA    = 2'd2;
  localparam logic [1:0] M_UART   = 2'd3;

  // Binary master index to one-hot 4-bit vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Purpose : combinational 4-way round-robin priority picker.
// Latency : none (pure combinational).
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req   [3:0] per-master request vector
//   last  [1:0] index of the most recent winner; scanning starts at last+1
//   valid       at least one request is asserted
//   idx   [1:0] index of the chosen master (M_IFETCH when valid is low)
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan last+1, last+2, last+3, last (2-bit wrap gives the mod 4); the
  // first asserted request wins, so the previous winner has lowest priority.
  always_comb begin
    valid = 1'b0;
    idx   = M_IFETCH;
    cand  = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Purpose : round-robin arbiter for the shared 32-bit system bus, with bus
//           lock and a watchdog that aborts a transfer to a dead slave.
// Latency : req to gnt/sel/s_stb is 1 cycle; s_ack to m_ack is 1 cycle.
// Backpressure: masters hold req until m_ack or m_err; the slave stalls the
//           owner simply by withholding s_ack (bounded by the watchdog).
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   req     [3:0] per-master request, held until m_ack / m_err
//   lock    [3:0] per-master lock, keeps ownership for the next request
//   s_ack   slave transfer-complete, only looked at while BUSY
//   gnt     [3:0] one-hot grant (registered)
//   sel     [1:0] owner index for the address/data/control muxes (registered)
//   s_stb   transfer strobe to the slave, high in BUSY (registered)
//   m_ack   [3:0] one-cycle done pulse to the owner (registered)
//   m_err   [3:0] one-cycle timeout pulse to the owner (registered)
//   busy    bus owned (state != IDLE)
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       s_ack,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       s_stb,
  output logic [3:0] m_ack,
  output logic [3:0] m_err,
  output logic       busy
);

  // Watchdog value on the last BUSY cycle before the transfer is aborted.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           st, st_nxt;
  logic [1:0]       last, last_nxt;
  logic [CNT_W-1:0] wdog, wdog_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       sel_nxt;
  logic             stb_nxt;
  logic [3:0]       ack_nxt;
  logic [3:0]       err_nxt;

  logic             pick_vld;
  logic [1:0]       pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Registered state and outputs. Reset mid-transfer drops everything,
  // including any pending ack/err pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      last  <= M_UART;
      wdog  <= '0;
      gnt   <= '0;
      sel   <= M_IFETCH;
      s_stb <= 1'b0;
      m_ack <= '0;
      m_err <= '0;
    end else begin
      st    <= st_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      s_stb <= stb_nxt;
      m_ack <= ack_nxt;
      m_err <= err_nxt;
    end
  end

  // Next-state and next-output logic. sel always names the owner while
  // BUSY/HOLD, so lock/req of the owner are looked up through it.
  always_comb begin
    st_nxt   = st;
    last_nxt = last;
    wdog_nxt = wdog;
    gnt_nxt  = gnt;
    sel_nxt  = sel;
    stb_nxt  = s_stb;
    ack_nxt  = '0;
    err_nxt  = '0;

    case (st)
      ST_IDLE: begin
        // The round-robin pointer only moves on a fresh grant from IDLE,
        // so a locked owner re-entering BUSY from HOLD does not rotate it.
        if (pick_vld) begin
          st_nxt   = ST_BUSY;
          gnt_nxt  = onehot4(pick_idx);
          sel_nxt  = pick_idx;
          stb_nxt  = 1'b1;
          last_nxt = pick_idx;
          wdog_nxt = '0;
        end
      end

      ST_BUSY: begin
        wdog_nxt = wdog + CNT_W'(1);
        // Priority: ack beats abort beats timeout, so an ack on the
        // watchdog's final cycle still completes the transfer cleanly.
        if (s_ack) begin
          ack_nxt = onehot4(sel);
          stb_nxt = 1'b0;
          if (lock[sel]) begin
            st_nxt = ST_HOLD;
          end else begin
            st_nxt  = ST_IDLE;
            gnt_nxt = '0;
          end
        end else if (!req[sel]) begin
          st_nxt  = ST_IDLE;
          gnt_nxt = '0;
          stb_nxt = 1'b0;
        end else if (wdog == WD_LAST) begin
          err_nxt = onehot4(sel);
          st_nxt  = ST_IDLE;
          gnt_nxt = '0;
          stb_nxt = 1'b0;
        end
      end

      ST_HOLD: begin
        // Other masters are deliberately ignored here: the locked owner
        // gets exactly one look at the bus before arbitration resumes.
        if (req[sel]) begin
          st_nxt   = ST_BUSY;
          stb_nxt  = 1'b1;
          wdog_nxt = '0;
        end else begin
          st_nxt  = ST_IDLE;
          gnt_nxt = '0;
        end
      end

      default: begin
        st_nxt  = ST_IDLE;
        gnt_nxt = '0;
        stb_nxt = 1'b0;
      end
    endcase
  end

  assign busy = (st != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 with a small watchdog (4 cycles).
// Each step queues the expected post-edge outputs, advances one clock and
// compares the DUT against the popped expectation.
module tb_bus_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic       s_ack;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       s_stb;
  logic [3:0] m_ack;
  logic [3:0] m_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  bus_arbiter4 #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lock  (lock),
    .s_ack (s_ack),
    .gnt   (gnt),
    .sel   (sel),
    .s_stb (s_stb),
    .m_ack (m_ack),
    .m_err (m_err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int m);
    logic [3:0] one;
    one = 4'b0001;
    return one << m;
  endfunction

  // Queue the expected outputs after the next edge, clock once, then
  // compare. busy is expected whenever some master holds the grant.
  task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] s,
                     input logic stb, input logic [3:0] a, input logic [3:0] e);
    logic [15:0] obs;
    logic [15:0] ev;
    string       t;
    exp_q.push_back({g, s, stb, a, e, (g != 4'b0000)});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs = {gnt, sel, s_stb, m_ack, m_err, busy};
    ev  = exp_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (obs === ev) else begin
      errors++;
      $error("FAIL %s: observed gnt=%b sel=%0d stb=%b ack=%b err=%b busy=%b, expected gnt=%b sel=%0d stb=%b ack=%b err=%b busy=%b",
             t, obs[15:12], obs[11:10], obs[9], obs[8:5], obs[4:1], obs[0],
             ev[15:12], ev[11:10], ev[9], ev[8:5], ev[4:1], ev[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    s_ack = 1'b0;

    // Reset held two cycles with every master requesting.
    cyc("rst0", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
    cyc("rst1", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    cyc("first_gnt", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);

    // Round robin 0,1,2,3,0 with s_ack two cycles after each grant.
    for (int k = 0; k < 5; k++) begin
      int m;
      int nm;
      m  = k % 4;
      nm = (k + 1) % 4;
      s_ack = 1'b0;
      cyc("rr_busy", oh(m), 2'(m), 1'b1, 4'b0000, 4'b0000);
      s_ack = 1'b1;
      cyc("rr_ack", 4'b0000, 2'(m), 1'b0, oh(m), 4'b0000);
      s_ack = 1'b0;
      if (k < 4) cyc("rr_next", oh(nm), 2'(nm), 1'b1, 4'b0000, 4'b0000);
    end
    req = 4'b0000;
    cyc("rr_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);

    // Lock: master 2 keeps the bus through HOLD while master 0 waits.
    req  = 4'b0101;
    lock = 4'b0100;
    cyc("lk_gnt2", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    cyc("lk_ack_hold", 4'b0100, 2'd2, 1'b0, 4'b0100, 4'b0000);
    s_ack = 1'b0;
    cyc("lk_regrant", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
    lock  = 4'b0000;
    s_ack = 1'b1;
    cyc("lk_ack_rel", 4'b0000, 2'd2, 1'b0, 4'b0100, 4'b0000);
    s_ack = 1'b0;
    cyc("lk_m0_next", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    cyc("lk_m0_ack", 4'b0000, 2'd0, 1'b0, 4'b0001, 4'b0000);
    s_ack = 1'b0;

    // Timeout: master 1, no s_ack; err 4 cycles after s_stb rises.
    req = 4'b0010;
    cyc("to_gnt1", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++)
      cyc("to_wait", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    cyc("to_err", 4'b0000, 2'd1, 1'b0, 4'b0000, 4'b0010);
    req = 4'b0000;
    cyc("to_idle", 4'b0000, 2'd1, 1'b0, 4'b0000, 4'b0000);

    // Master 3 abandons mid-BUSY; next scan starts at master 0.
    req = 4'b1000;
    cyc("ab_gnt3", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
    cyc("ab_busy", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
    req = 4'b0000;
    cyc("ab_drop", 4'b0000, 2'd3, 1'b0, 4'b0000, 4'b0000);
    req = 4'b1001;
    cyc("ab_next0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);

    // s_ack arrives on the watchdog's final cycle: ack wins.
    for (int i = 0; i < 3; i++)
      cyc("ct_wait", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    cyc("ct_ack_wins", 4'b0000, 2'd0, 1'b0, 4'b0001, 4'b0000);
    s_ack = 1'b0;
    req   = 4'b0000;
    cyc("ct_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);

    // Locked owner that does not re-request leaves HOLD for IDLE.
    req  = 4'b0100;
    lock = 4'b0100;
    cyc("hr_gnt2", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    cyc("hr_ack", 4'b0100, 2'd2, 1'b0, 4'b0100, 4'b0000);
    s_ack = 1'b0;
    req   = 4'b0000;
    lock  = 4'b0000;
    cyc("hr_release", 4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000);

    // Reset mid-transfer: no ack despite s_ack; pointer back to 3.
    req = 4'b0001;
    cyc("rm_gnt0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    s_ack = 1'b1;
    cyc("rm_reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    s_ack = 1'b0;
    req   = 4'b1111;
    cyc("rm_regrant0", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
